mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the next-generation core; replaces the fixed 5-phase control unit.
- Adds req/ack handshakes to instruction and data memory, so memory latency is variable.
- Adds a retired-instruction counter, a HALT state and parametrised PC width/step.
- Sits between an external opcode pre-decoder and the datapath: PC, IR, register file and memory-port muxes.

Parameters:
- ADDR_W, 32, width of the pc_step output.
- PC_STEP, 1, PC increment per instruction (1 = word addressing, 4 = byte addressing).
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 15, maximum cycles to wait for an ack (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cls  in  3  instruction class, valid in ID/EXE/MEM/WB: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 JAL, 7 JR.
- halt_op  in  1  decoded halt instruction, valid in ID.
- br_taken  in  1  branch condition from ZF/SF, valid in EXE.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- ir_wr  out  1  load IR.
- pc_wr  out  1  load PC.
- pc_src  out  2  next-PC select: 0 PC+step, 1 branch target, 2 register, 3 jump target.
- reg_wr  out  1  register file write.
- reg_dst  out  2  write register select: 0 r31, 1 rt, 2 rd.
- wr_src  out  1  write data select: 0 PC+step, 1 data bus.
- alu_src_b  out  1  ALU B operand select: 0 register, 1 extended immediate.
- pc_step  out  ADDR_W  constant PC_STEP.
- state  out  3  current state, for debug.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5, FAULT=6. State and counter are registered; strobes are combinational from state and inputs.
- Reset (rst low, asynchronous): state=IF, retired=0. While rst is low, every strobe and req output is 0.
- IF:
  - imem_req=1 and held high until imem_ack.
  - On imem_ack: ir_wr=1 for that cycle, then go to ID.
  - imem_ack with no request outstanding is ignored.
- ID:
  - halt_op set: go to HALT, no PC write.
  - JUMP: pc_wr=1, pc_src=3, go to IF.
  - JAL: pc_wr=1, pc_src=3, reg_wr=1, reg_dst=0, wr_src=0, go to IF.
  - JR: pc_wr=1, pc_src=2, go to IF.
  - Any other class: go to EXE.
- EXE:
  - alu_src_b=1 for ALU_I, LOAD and STORE; 0 otherwise.
  - BRANCH: pc_wr=1, pc_src=br_taken?1:0, go to IF.
  - LOAD or STORE: go to MEM.
  - ALU_R or ALU_I: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE. Both held stable until dmem_ack.
  - On ack, STORE: pc_wr=1, pc_src=0, go to IF.
  - On ack, LOAD: go to WB.
- WB:
  - reg_wr=1; pc_wr=1; pc_src=0; go to IF.
  - reg_dst=2 for ALU_R, 1 otherwise; wr_src=1.
- Instruction latencies, assuming zero-wait acks (ack in the same cycle as req):
  - Jumps: 2 cycles.
  - Branch and ALU: 3/4 cycles.
  - Load: 5 cycles.
- retired increments by 1 on every cycle where pc_wr=1. It wraps modulo 2^CNT_W.
- HALT: all strobes 0, halted=1. HALT is left only by reset.
- Reset mid-handshake drops the req immediately. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: MC_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A wait counter counts consecutive IF or MEM cycles without an ack; it clears on ack or on a state change.
  - When the count reaches TIMEOUT, the next state is FAULT.
  - In FAULT: fault=1, all strobes 0, left only by reset.
- Without the macro: no counter, FAULT is unreachable, fault is tied to 0, and the wait is unbounded.

Decomposition:
- Package mc_pkg holds:
  - the state enum;
  - the cls encodings;
  - the pc_src and reg_dst encodings.
- No sub-module. The timeout counter is an inline generate block.

Test Plan:
- Reset, then ALU_R with imem_ack and dmem_ack tied 1:
  - IF→ID→EXE→WB→IF;
  - reg_wr, reg_dst=2 and pc_wr, pc_src=0 in WB;
  - retired=1.
- LOAD with dmem_ack delayed 3 cycles:
  - dmem_req held high for 4 cycles, dmem_we=0;
  - WB writes with reg_dst=1, wr_src=1.
- BRANCH, br_taken=1 then 0:
  - first instruction gives pc_src=1 in EXE;
  - second gives pc_src=0;
  - both take 3 cycles.
- JAL then halt_op:
  - JAL: reg_dst=0, wr_src=0, pc_src=3 in ID;
  - halt: halted=1 and remains 1 for 20 cycles with no strobes.
- rst driven low mid-MEM:
  - dmem_req falls without a clock edge;
  - after release, state=IF and retired=0.
- MC_SEQ_TIMEOUT_EN defined, TIMEOUT=15, imem_ack held 0:
  - fault=1 after 15 IF cycles;
  - imem_req=0 afterwards.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states, instruction classes,
// next-PC and write-register selects.
package mc_pkg;

    localparam logic [2:0] StIf    = 3'd0;
    localparam logic [2:0] StId    = 3'd1;
    localparam logic [2:0] StExe   = 3'd2;
    localparam logic [2:0] StMem   = 3'd3;
    localparam logic [2:0] StWb    = 3'd4;
    localparam logic [2:0] StHalt  = 3'd5;
    localparam logic [2:0] StFault = 3'd6;

    localparam logic [2:0] ClsAluR   = 3'd0;
    localparam logic [2:0] ClsAluI   = 3'd1;
    localparam logic [2:0] ClsLoad   = 3'd2;
    localparam logic [2:0] ClsStore  = 3'd3;
    localparam logic [2:0] ClsBranch = 3'd4;
    localparam logic [2:0] ClsJump   = 3'd5;
    localparam logic [2:0] ClsJal    = 3'd6;
    localparam logic [2:0] ClsJr     = 3'd7;

    localparam logic [1:0] PcSrcStep   = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcReg    = 2'd2;
    localparam logic [1:0] PcSrcJump   = 2'd3;

    localparam logic [1:0] DstR31 = 2'd0;
    localparam logic [1:0] DstRt  = 2'd1;
    localparam logic [1:0] DstRd  = 2'd2;

    // Classes whose ALU B operand is the extended immediate.
    function automatic logic uses_imm(input logic [2:0] c);
        return (c == ClsAluI) || (c == ClsLoad) || (c == ClsStore);
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer with req/ack memory handshakes and a retired counter.
// Optional ack timeout into a FAULT state is enabled by defining MC_SEQ_TIMEOUT_EN.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned PC_STEP = 1,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cls,
    input  logic              halt_op,
    input  logic              br_taken,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_wr,
    output logic              pc_wr,
    output logic [1:0]        pc_src,
    output logic              reg_wr,
    output logic [1:0]        reg_dst,
    output logic              wr_src,
    output logic              alu_src_b,
    output logic [ADDR_W-1:0] pc_step,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);

`ifdef MC_SEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             timeout;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_wr_c, pc_wr_c;
    logic       reg_wr_c, wr_src_c, alu_src_b_c;
    logic [1:0] pc_src_c, reg_dst_c;

    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_wr_c     = 1'b0;
        pc_wr_c     = 1'b0;
        pc_src_c    = PcSrcStep;
        reg_wr_c    = 1'b0;
        reg_dst_c   = DstR31;
        wr_src_c    = 1'b0;
        alu_src_b_c = 1'b0;

        case (state_q)
            StIf: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_wr_c = 1'b1;
                    state_d = StId;
                end
            end
            StId: begin
                if (halt_op) begin
                    state_d = StHalt;
                end else begin
                    case (cls)
                        ClsJump: begin
                            pc_wr_c  = 1'b1;
                            pc_src_c = PcSrcJump;
                            state_d  = StIf;
                        end
                        ClsJal: begin
                            pc_wr_c   = 1'b1;
                            pc_src_c  = PcSrcJump;
                            reg_wr_c  = 1'b1;
                            reg_dst_c = DstR31;
                            wr_src_c  = 1'b0;
                            state_d   = StIf;
                        end
                        ClsJr: begin
                            pc_wr_c  = 1'b1;
                            pc_src_c = PcSrcReg;
                            state_d  = StIf;
                        end
                        default: state_d = StExe;
                    endcase
                end
            end
            StExe: begin
                alu_src_b_c = uses_imm(cls);
                case (cls)
                    ClsBranch: begin
                        pc_wr_c  = 1'b1;
                        pc_src_c = br_taken ? PcSrcBranch : PcSrcStep;
                        state_d  = StIf;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsAluR, ClsAluI:  state_d = StWb;
                    default:           state_d = StIf;
                endcase
            end
            StMem: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls == ClsStore);
                if (dmem_ack) begin
                    if (cls == ClsStore) begin
                        pc_wr_c  = 1'b1;
                        pc_src_c = PcSrcStep;
                        state_d  = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_wr_c  = 1'b1;
                pc_wr_c   = 1'b1;
                pc_src_c  = PcSrcStep;
                reg_dst_c = (cls == ClsAluR) ? DstRd : DstRt;
                wr_src_c  = 1'b1;
                state_d   = StIf;
            end
            StHalt, StFault: state_d = state_q;
            default:         state_d = StIf;
        endcase

        if (timeout) begin
            state_d = StFault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIf;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_wr_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mc_sequencer: TIMEOUT must be at least 1");
    end

    if (TimeoutEn) begin : g_timeout
        localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

        logic [WaitW-1:0] wait_q, wait_d;
        logic             waiting;

        // Only a stalled IF or MEM cycle stays in place, so clearing whenever not waiting
        // also covers every state change.
        always_comb begin
            waiting = ((state_q == StIf) && !imem_ack) || ((state_q == StMem) && !dmem_ack);
            wait_d  = waiting ? wait_q + WaitW'(1) : '0;
        end

        assign timeout = waiting && (wait_q == WaitW'(TIMEOUT - 1));
        assign fault   = (state_q == StFault);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end
    end else begin : g_no_timeout
        assign timeout = 1'b0;
        assign fault   = 1'b0;
    end

    // Outputs are forced low while reset is asserted so an abandoned handshake drops at once.
    assign imem_req  = rst & imem_req_c;
    assign dmem_req  = rst & dmem_req_c;
    assign dmem_we   = rst & dmem_we_c;
    assign ir_wr     = rst & ir_wr_c;
    assign pc_wr     = rst & pc_wr_c;
    assign reg_wr    = rst & reg_wr_c;
    assign wr_src    = rst & wr_src_c;
    assign alu_src_b = rst & alu_src_b_c;
    assign pc_src    = rst ? pc_src_c : 2'd0;
    assign reg_dst   = rst ? reg_dst_c : 2'd0;

    assign pc_step = ADDR_W'(PC_STEP);
    assign state   = state_q;
    assign halted  = (state_q == StHalt);
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer; the timeout section follows MC_SEQ_TIMEOUT_EN.
module tb_mc_sequencer;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        cls;
    logic              halt_op, br_taken, imem_ack, dmem_ack;
    logic              imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, wr_src, alu_src_b;
    logic [1:0]        pc_src, reg_dst;
    logic [ADDR_W-1:0] pc_step;
    logic [2:0]        state;
    logic              halted, fault;
    logic [CNT_W-1:0]  retired;

    int n_checks = 0;
    int n_pass   = 0;

    mc_sequencer #(
        .ADDR_W  (ADDR_W),
        .PC_STEP (PC_STEP),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cls       (cls),
        .halt_op   (halt_op),
        .br_taken  (br_taken),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .ir_wr     (ir_wr),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wr_src    (wr_src),
        .alu_src_b (alu_src_b),
        .pc_step   (pc_step),
        .state     (state),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic seen;
        logic hold_ok;
        logic [6:0] strobes;

        rst      = 1'b0;
        cls      = 3'd0;
        halt_op  = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #12;
        check("rst_state", 64'(state), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_ir_wr", 64'(ir_wr), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("pc_step", 64'(pc_step), 64'd4);

        // ALU_R with both acks tied high: IF -> ID -> EXE -> WB -> IF.
        rst = 1'b1;
        #1;
        check("alu_if", 64'({state, imem_req, ir_wr}), 64'({3'd0, 1'b1, 1'b1}));
        tick();
        check("alu_id", 64'(state), 64'd1);
        tick();
        check("alu_exe", 64'({state, alu_src_b, pc_wr}), 64'({3'd2, 1'b0, 1'b0}));
        tick();
        check("alu_wb", 64'({state, reg_wr, reg_dst, wr_src, pc_wr, pc_src}),
              64'({3'd4, 1'b1, 2'd2, 1'b1, 1'b1, 2'd0}));
        tick();
        check("alu_back_if", 64'(state), 64'd0);
        check("alu_retired", 64'(retired), 64'd1);

        // LOAD with dmem_ack arriving on the fourth MEM cycle.
        cls      = 3'd2;
        dmem_ack = 1'b0;
        tick();
        tick();
        check("ld_exe", 64'({state, alu_src_b}), 64'({3'd2, 1'b1}));
        tick();
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (dmem_req === 1'b1 && state == 3'd3) n++;
            seen = seen | dmem_we | pc_wr;
            if (i < 3) tick();
        end
        check("ld_req_cycles", 64'(n), 64'd4);
        check("ld_we_pcwr", 64'(seen), 64'd0);
        tick();
        check("ld_wb", 64'({state, reg_wr, reg_dst, wr_src, pc_wr}),
              64'({3'd4, 1'b1, 2'd1, 1'b1, 1'b1}));
        tick();
        check("ld_retired", 64'(retired), 64'd2);

        // BRANCH taken, then not taken; 3 cycles each.
        cls      = 3'd4;
        br_taken = 1'b1;
        tick();
        tick();
        check("br1_exe", 64'({state, pc_wr, pc_src}), 64'({3'd2, 1'b1, 2'd1}));
        tick();
        check("br1_if", 64'({state, retired}), 64'({3'd0, 32'd3}));
        br_taken = 1'b0;
        tick();
        tick();
        check("br0_exe", 64'({state, pc_wr, pc_src}), 64'({3'd2, 1'b1, 2'd0}));
        tick();
        check("br0_if", 64'({state, retired}), 64'({3'd0, 32'd4}));

        // JAL completes from ID.
        cls = 3'd6;
        tick();
        check("jal_id", 64'({state, pc_wr, pc_src, reg_wr, reg_dst, wr_src}),
              64'({3'd1, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0}));
        tick();
        check("jal_if", 64'({state, retired}), 64'({3'd0, 32'd5}));

        // HALT: sticky, no strobes, counter frozen.
        cls     = 3'd0;
        halt_op = 1'b1;
        tick();
        check("halt_id_pcwr", 64'(pc_wr), 64'd0);
        tick();
        halt_op = 1'b0;
        check("halt_entry", 64'({state, halted}), 64'({3'd5, 1'b1}));
        hold_ok = 1'b1;
        strobes = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hold_ok = hold_ok & halted & (state == 3'd5);
            strobes = strobes | {imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, alu_src_b};
        end
        check("halt_hold", 64'(hold_ok), 64'd1);
        check("halt_strobes", 64'(strobes), 64'd0);
        check("halt_retired", 64'(retired), 64'd5);

        // Only reset leaves HALT.
        #1;
        rst = 1'b0;
        #1;
        check("rst_exit_halt", 64'({state, halted, retired}), 64'({3'd0, 1'b0, 32'd0}));
        rst = 1'b1;

        // STORE with immediate ack retires from MEM.
        cls      = 3'd3;
        dmem_ack = 1'b1;
        tick();
        tick();
        tick();
        check("st_mem", 64'({state, dmem_req, dmem_we, pc_wr, pc_src, alu_src_b}),
              64'({3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0}));
        tick();
        check("st_retired", 64'({state, retired}), 64'({3'd0, 32'd1}));

        // Second STORE stalls in MEM, then reset lands between clock edges.
        dmem_ack = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("st_wait", 64'({state, dmem_req, dmem_we}), 64'({3'd3, 1'b1, 1'b1}));
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_mem", 64'({state, dmem_req, dmem_we, imem_req}), 64'({3'd0, 3'b000}));
        #2;
        rst = 1'b1;
        #1;
        check("rst_release", 64'({state, retired, imem_req}), 64'({3'd0, 32'd0, 1'b1}));

        // Fetch with no ack: bounded by TIMEOUT only when the timeout is built in.
        imem_ack = 1'b0;
        n        = 0;
        for (int i = 0; i < 15; i++) begin
            if (state == 3'd0 && imem_req === 1'b1 && fault === 1'b0) n++;
            tick();
        end
        check("wait_if_cycles", 64'(n), 64'd15);
`ifdef MC_SEQ_TIMEOUT_EN
        check("to_fault", 64'({state, fault, imem_req}), 64'({3'd6, 1'b1, 1'b0}));
        imem_ack = 1'b1;
        tick();
        check("to_sticky", 64'({state, fault, imem_req, ir_wr}), 64'({3'd6, 1'b1, 1'b0, 1'b0}));
`else
        check("no_to_still_if", 64'({state, fault, imem_req}), 64'({3'd0, 1'b0, 1'b1}));
        imem_ack = 1'b1;
        #1;
        check("no_to_ack", 64'({ir_wr, fault}), 64'({1'b1, 1'b0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
